// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- MEM/WB pipeline register plus write-back, syscall and halt logic
//
// Captures the MEM-stage instruction into the MEM/WB register, then drives the
// register-file write port (RegWrite / w1_num / Reg_write_data) straight from
// that register so the decode stage can write on the following negedge.
// Syscalls retire here: a syscall whose $v0 equals HALT_CODE halts the core;
// any other syscall latches $a0 into disp_data and pulses disp_valid.
//
// Handshake: there is no valid/ready pair. An instruction held in the MEM/WB
// register retires at the end of a cycle in which it is valid, stall is low
// and the FSM is in RUN. stall holds the register; flush clears the captured
// valid on the next edge and takes priority over stall.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   stall, flush      hold register / insert bubble (flush wins)
//   in_*              MEM-stage instruction fields and result sources
//   RegWrite          register-file write enable
//   w1_num            register-file write index
//   Reg_write_data    register-file write data
//   halt              sticky halt flag (FSM in HALT)
//   disp_data         last displayed syscall value
//   disp_valid        one-cycle pulse when disp_data updates
//   retired_count     retired instruction count (wraps)
//   state_dbg         FSM state for observation (0 = RUN, 1 = HALT)
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter logic [4:0]  JAL_REG   = 5'd31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_reg_write,
    input  logic        in_memtoreg,
    input  logic        in_jal,
    input  logic        in_regdst,
    input  logic        in_syscall,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_mem_data,
    input  logic [31:0] in_pc_plus_4,
    input  logic [31:0] in_v0,
    input  logic [31:0] in_a0,
    output logic        RegWrite,
    output logic [4:0]  w1_num,
    output logic [31:0] Reg_write_data,
    output logic        halt,
    output logic [31:0] disp_data,
    output logic        disp_valid,
    output logic [31:0] retired_count,
    output logic        state_dbg
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // MEM/WB pipeline register
    logic        r_valid;
    logic        r_reg_write;
    logic        r_memtoreg;
    logic        r_jal;
    logic        r_regdst;
    logic        r_syscall;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [31:0] r_alu_result;
    logic [31:0] r_mem_data;
    logic [31:0] r_pc_plus_4;
    logic [31:0] r_v0;
    logic [31:0] r_a0;

    logic [31:0] cnt_q;
    logic [31:0] disp_data_q;
    logic        disp_valid_q;

    logic        retire;
    logic        halt_hit;
    logic        disp_hit;

    // -------------------------------------------------------------------------
    // MEM/WB register. On flush only valid is cleared; the stale fields are
    // harmless because every consumer is qualified by r_valid.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_jal        <= 1'b0;
            r_regdst     <= 1'b0;
            r_syscall    <= 1'b0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
            r_alu_result <= 32'd0;
            r_mem_data   <= 32'd0;
            r_pc_plus_4  <= 32'd0;
            r_v0         <= 32'd0;
            r_a0         <= 32'd0;
        end else if (flush) begin
            r_valid      <= 1'b0;
        end else if (!stall) begin
            r_valid      <= in_valid;
            r_reg_write  <= in_reg_write;
            r_memtoreg   <= in_memtoreg;
            r_jal        <= in_jal;
            r_regdst     <= in_regdst;
            r_syscall    <= in_syscall;
            r_rt         <= in_rt;
            r_rd         <= in_rd;
            r_alu_result <= in_alu_result;
            r_mem_data   <= in_mem_data;
            r_pc_plus_4  <= in_pc_plus_4;
            r_v0         <= in_v0;
            r_a0         <= in_a0;
        end
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and retirement decode. A stalled instruction does not
    // retire this cycle, so it is counted exactly once: in the cycle the stall
    // finally drops.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        halt_hit = 1'b0;
        disp_hit = 1'b0;
        case (state_q)
            S_RUN: begin
                retire = r_valid && !stall;
                if (retire && r_syscall) begin
                    if (r_v0 == HALT_CODE) begin
                        halt_hit = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        disp_hit = 1'b1;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Write-back port, combinational from the MEM/WB register
    // -------------------------------------------------------------------------
    always_comb begin
        w1_num = r_rt;
        if (r_jal) begin
            w1_num = JAL_REG;
        end else if (r_regdst) begin
            w1_num = r_rd;
        end
    end

    always_comb begin
        Reg_write_data = r_alu_result;
        if (r_jal) begin
            Reg_write_data = r_pc_plus_4;
        end else if (r_memtoreg) begin
            Reg_write_data = r_mem_data;
        end
    end

    // Syscalls never write the register file, and writes to $0 are dropped
    // here so the register file never sees them.
    assign RegWrite = (state_q == S_RUN) && r_valid && (r_reg_write || r_jal)
                      && !r_syscall && (w1_num != 5'd0) && !stall;

    // -------------------------------------------------------------------------
    // Display register, retirement counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data_q  <= 32'd0;
            disp_valid_q <= 1'b0;
        end else begin
            disp_valid_q <= disp_hit;
            if (disp_hit) begin
                disp_data_q <= r_a0;
            end
        end
    end

    // Natural 32-bit wrap from 0xFFFFFFFF to 0; halt_hit is a retirement too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else if (retire) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign halt          = (state_q == S_HALT);
    assign disp_data     = disp_data_q;
    assign disp_valid    = disp_valid_q;
    assign retired_count = cnt_q;
    assign state_dbg     = state_q;

    // halt_hit only feeds the state transition above; kept as a named term
    // for checkers.
    logic halt_hit_unused;
    assign halt_hit_unused = halt_hit;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_reg_write;
  logic        in_memtoreg;
  logic        in_jal;
  logic        in_regdst;
  logic        in_syscall;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [31:0] in_pc_plus_4;
  logic [31:0] in_v0;
  logic [31:0] in_a0;
  logic        RegWrite;
  logic [4:0]  w1_num;
  logic [31:0] Reg_write_data;
  logic        halt;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [31:0] retired_count;
  logic        state_dbg;

  int          n_tests;
  int          n_fail;

  // scoreboard: {RegWrite, w1_num, Reg_write_data}
  logic [37:0] exp_q[$];
  logic [37:0] got;
  logic [37:0] exp;
  logic [31:0] exp_cnt;
  logic        model_halted;

  wb_stage #(.HALT_CODE(32'd10), .JAL_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_memtoreg(in_memtoreg),
    .in_jal(in_jal), .in_regdst(in_regdst), .in_syscall(in_syscall),
    .in_rt(in_rt), .in_rd(in_rd), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus_4(in_pc_plus_4),
    .in_v0(in_v0), .in_a0(in_a0),
    .RegWrite(RegWrite), .w1_num(w1_num), .Reg_write_data(Reg_write_data),
    .halt(halt), .disp_data(disp_data), .disp_valid(disp_valid),
    .retired_count(retired_count), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 0; in_reg_write = 0; in_memtoreg = 0; in_jal = 0;
    in_regdst = 0; in_syscall = 0; in_rt = 0; in_rd = 0;
    in_alu_result = 0; in_mem_data = 0; in_pc_plus_4 = 0; in_v0 = 0; in_a0 = 0;
  endtask

  // Drives one instruction at a negedge, pushes the expected write-back and
  // returns at the negedge after capture, when the write port is valid.
  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic jal, input logic rdst, input logic sc,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [31:0] pc4, input logic [31:0] v0,
                       input logic [31:0] a0);
    logic [4:0]  e_w1;
    logic [31:0] e_data;
    logic        e_wr;
    in_valid = v; in_reg_write = rw; in_memtoreg = m2r; in_jal = jal;
    in_regdst = rdst; in_syscall = sc; in_rt = rt; in_rd = rd;
    in_alu_result = alu; in_mem_data = mem; in_pc_plus_4 = pc4;
    in_v0 = v0; in_a0 = a0;
    e_w1   = jal ? 5'd31 : (rdst ? rd : rt);
    e_data = jal ? pc4 : (m2r ? mem : alu);
    e_wr   = v && (rw || jal) && !sc && (e_w1 != 5'd0) && !model_halted;
    exp_q.push_back({e_wr, e_w1, e_data});
    if (v && !model_halted) begin
      exp_cnt = exp_cnt + 32'd1;
      if (sc && v0 == 32'd10) model_halted = 1'b1;
    end
    step();
  endtask

  function automatic logic [37:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; idle_in();
    #2;
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite got %0h exp 0", RegWrite); end
    n_tests++; if (w1_num !== 5'd0) begin n_fail++; $display("FAIL reset_w1 got %0h exp 0", w1_num); end
    n_tests++; if (Reg_write_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %0h exp 0", Reg_write_data); end
    n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %0h exp 0", halt); end
    n_tests++; if ({disp_valid, disp_data} !== 33'd0) begin n_fail++; $display("FAIL reset_disp got %0h/%0h exp 0/0", disp_valid, disp_data); end
    n_tests++; if (retired_count !== 32'd0) begin n_fail++; $display("FAIL reset_count got %0h exp 0", retired_count); end
    @(negedge clk);
    rst = 0;
    step();
    n_tests++; if ({RegWrite, retired_count} !== 33'd0) begin n_fail++; $display("FAIL reset_idle got %0h/%0h exp 0/0", RegWrite, retired_count); end
  endtask

  task automatic test_alu();
    drive(1, 1, 0, 0, 1, 0, 5'd3, 5'd8, 32'h1234, 32'h9999, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL alu_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if (retired_count !== 32'd1) begin n_fail++; $display("FAIL alu_count got %0h exp 1", retired_count); end
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %0h exp 0", RegWrite); end
  endtask

  task automatic test_jal();
    drive(1, 0, 0, 1, 1, 0, 5'd4, 5'd3, 32'h99, 32'h77, 32'h0040_0010, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL jal_wb got %h exp %h", got, exp); end
    n_tests++; if (got !== {1'b1, 5'd31, 32'h0040_0010}) begin n_fail++; $display("FAIL jal_const got %h exp %h", got, {1'b1, 5'd31, 32'h0040_0010}); end
    idle_in(); step();
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL jal_count got %0h exp %0h", retired_count, exp_cnt); end
  endtask

  task automatic test_load_zero();
    drive(1, 1, 1, 0, 0, 0, 5'd0, 5'd7, 32'h11, 32'h55, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL load0_wb got %h exp %h", got, exp); end
    drive(1, 1, 1, 0, 0, 0, 5'd9, 5'd7, 32'h11, 32'hCAFE, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL load9_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL load_count got %0h exp %0h", retired_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom, 32'h0, 32'h0);
      got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL b2b_wb[%0d] got %h exp %h", i, got, exp); end
    end
    idle_in(); step();
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_count got %0h exp %0h", retired_count, exp_cnt); end
  endtask

  task automatic test_stall();
    drive(1, 1, 0, 0, 1, 0, 5'd1, 5'd5, 32'hABCD, 32'h0, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL stall_first got %h exp %h", got, exp); end
    stall = 1;
    in_valid = 1; in_reg_write = 1; in_regdst = 1; in_rd = 5'd12; in_alu_result = 32'h777;
    #1;
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL stall_gate got %0h exp 0", RegWrite); end
    for (int i = 0; i < 3; i++) begin
      step();
      got = {RegWrite, w1_num, Reg_write_data};
      n_tests++; if (got !== {1'b0, 5'd5, 32'hABCD}) begin n_fail++; $display("FAIL stall_hold[%0d] got %h exp %h", i, got, {1'b0, 5'd5, 32'hABCD}); end
      n_tests++; if (retired_count !== exp_cnt - 32'd1) begin n_fail++; $display("FAIL stall_count[%0d] got %0h exp %0h", i, retired_count, exp_cnt - 32'd1); end
    end
    stall = 0; idle_in();
    #1;
    n_tests++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL stall_release got %0h exp 1", RegWrite); end
    step();
    n_tests++; if ({RegWrite, retired_count} !== {1'b0, exp_cnt}) begin n_fail++; $display("FAIL stall_single got %0h/%0h exp 0/%0h", RegWrite, retired_count, exp_cnt); end
  endtask

  task automatic test_flush();
    drive(1, 1, 0, 0, 1, 0, 5'd1, 5'd6, 32'h66, 32'h0, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL flush_first got %h exp %h", got, exp); end
    exp_cnt = exp_cnt - 32'd1;  // dropped by flush while stalled, never retires
    stall = 1; flush = 1;
    in_valid = 1; in_reg_write = 1; in_regdst = 1; in_rd = 5'd7; in_alu_result = 32'h70;
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_stall_bubble got %0h exp 0", RegWrite); end
    stall = 0; flush = 0; idle_in();
    step();
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL flush_stall_count got %0h exp %0h", retired_count, exp_cnt); end
    flush = 1;
    in_valid = 1; in_reg_write = 1; in_regdst = 1; in_rd = 5'd10; in_alu_result = 32'hA0;
    step();
    n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_bubble got %0h exp 0", RegWrite); end
    flush = 0; idle_in();
    step();
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL flush_count got %0h exp %0h", retired_count, exp_cnt); end
  endtask

  task automatic test_wrap();
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    drive(1, 1, 0, 0, 1, 0, 5'd0, 5'd3, 32'h33, 32'h0, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL wrap_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_zero got %0h exp %0h", retired_count, exp_cnt); end
    drive(1, 1, 0, 0, 1, 0, 5'd0, 5'd4, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL wrap_next_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_one got %0h exp %0h", retired_count, exp_cnt); end
  endtask

  task automatic test_syscall();
    drive(1, 1, 0, 0, 0, 1, 5'd2, 5'd0, 32'h42, 32'h0, 32'h0, 32'd1, 32'hDEAD);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL sys_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if ({disp_valid, disp_data} !== {1'b1, 32'hDEAD}) begin n_fail++; $display("FAIL sys_disp got %0h/%0h exp 1/dead", disp_valid, disp_data); end
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL sys_count got %0h exp %0h", retired_count, exp_cnt); end
    step();
    n_tests++; if ({disp_valid, disp_data} !== {1'b0, 32'hDEAD}) begin n_fail++; $display("FAIL sys_pulse got %0h/%0h exp 0/dead", disp_valid, disp_data); end
    n_tests++; if (halt !== 1'b0) begin n_fail++; $display("FAIL sys_nohalt got %0h exp 0", halt); end
    drive(1, 0, 0, 0, 0, 1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'd10, 32'hBEEF);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL halt_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if ({halt, state_dbg} !== 2'b11) begin n_fail++; $display("FAIL halt_set got %0h/%0h exp 1/1", halt, state_dbg); end
    n_tests++; if ({disp_valid, disp_data} !== {1'b0, 32'hDEAD}) begin n_fail++; $display("FAIL halt_disp got %0h/%0h exp 0/dead", disp_valid, disp_data); end
    n_tests++; if (retired_count !== exp_cnt) begin n_fail++; $display("FAIL halt_count got %0h exp %0h", retired_count, exp_cnt); end
    drive(1, 1, 0, 0, 1, 0, 5'd0, 5'd8, 32'h5555, 32'h0, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL halted_wb got %h exp %h", got, exp); end
    drive(1, 0, 0, 0, 0, 1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 32'd1, 32'hF00D);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL halted_sys_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if ({disp_valid, disp_data} !== {1'b0, 32'hDEAD}) begin n_fail++; $display("FAIL halted_disp got %0h/%0h exp 0/dead", disp_valid, disp_data); end
    n_tests++; if ({halt, retired_count} !== {1'b1, exp_cnt}) begin n_fail++; $display("FAIL halted_frozen got %0h/%0h exp 1/%0h", halt, retired_count, exp_cnt); end
  endtask

  task automatic test_reset_mid_halt();
    stall = 1;
    in_valid = 1; in_reg_write = 1; in_regdst = 1; in_rd = 5'd9; in_alu_result = 32'h99;
    #2;
    rst = 1;
    #1;
    n_tests++; if ({halt, state_dbg, RegWrite} !== 3'b000) begin n_fail++; $display("FAIL rst_halt got %0h/%0h/%0h exp 0/0/0", halt, state_dbg, RegWrite); end
    n_tests++; if ({w1_num, Reg_write_data} !== 37'd0) begin n_fail++; $display("FAIL rst_wb got %0h/%0h exp 0/0", w1_num, Reg_write_data); end
    n_tests++; if ({disp_valid, disp_data, retired_count} !== 65'd0) begin n_fail++; $display("FAIL rst_misc got %0h/%0h/%0h exp 0/0/0", disp_valid, disp_data, retired_count); end
    step();
    rst = 0; stall = 0;
    model_halted = 0; exp_cnt = 0;
    drive(1, 1, 0, 0, 1, 0, 5'd0, 5'd8, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0);
    got = {RegWrite, w1_num, Reg_write_data}; exp = pop_exp();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rst_first_wb got %h exp %h", got, exp); end
    idle_in(); step();
    n_tests++; if ({halt, retired_count} !== {1'b0, exp_cnt}) begin n_fail++; $display("FAIL rst_first_count got %0h/%0h exp 0/%0h", halt, retired_count, exp_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_tests = 0; n_fail = 0;
    exp_cnt = 0; model_halted = 0;
    test_reset();
    test_alu();
    test_jal();
    test_load_zero();
    test_back_to_back();
    test_stall();
    test_flush();
    test_wrap();
    test_syscall();
    test_reset_mid_halt();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
